// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CAP,
        ST_FIN
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h11000000;

    // Store data for byte piece idx of a split access, right-aligned.
    function automatic logic [31:0] piece_din(input logic [31:0] wdata, input logic [1:0] idx);
        logic [31:0] sh;
        sh = wdata >> {idx, 3'b000};
        return {24'h0, sh[7:0]};
    endfunction

endpackage

// File: rtl/otter_lsu_merge.sv
// Split decision, piece count and final extension of a split load.
module otter_lsu_merge
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)(
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_asm,
    output logic        o_split,
    output logic [1:0]  o_last,
    output logic [31:0] o_ext
);

    logic w_split;

    // Misaligned RAM accesses become byte pieces; MMIO is never split.
    always_comb begin
        w_split = (i_addr < IO_BASE) &&
                  (((i_size == SZ_HALF) && (i_addr[1:0] == 2'd3)) ||
                   ((i_size == SZ_WORD) && (i_addr[1:0] != 2'd0)));
        o_split = w_split;
        o_last  = 2'd0;
        if (w_split)
            o_last = (i_size == SZ_WORD) ? 2'd3 : 2'd1;
        o_ext = i_asm;
        if (i_size == SZ_HALF)
            o_ext = i_sign ? {16'h0, i_asm[15:0]} : {{16{i_asm[15]}}, i_asm[15:0]};
    end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit driving the data port of OTTER_mem_byte; splits
// word-crossing accesses into byte pieces and reassembles loads.
module otter_lsu
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        LSU_REQ,
    input  logic        LSU_WE,
    input  logic [31:0] LSU_ADDR,
    input  logic [31:0] LSU_WDATA,
    input  logic [1:0]  LSU_SIZE,
    input  logic        LSU_SIGN,
    output logic        LSU_READY,
    output logic        LSU_DONE,
    output logic [31:0] LSU_RDATA,
    output logic        LSU_ERR,
    output logic        LSU_SPLIT,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    lsu_state_t  r_state;
    logic [31:0] r_addr, r_wdata, r_asm, r_rdata;
    logic [1:0]  r_size, r_cnt, r_last;
    logic        r_sign, r_split;
    logic        r_done, r_err, r_split_q;
    logic [31:0] r_mem_addr, r_mem_din;
    logic        r_mem_wr, r_mem_rd, r_mem_sign;
    logic [1:0]  r_mem_size;

    logic [31:0] w_m_addr, w_ext, w_asm_nxt, w_nxt_addr;
    logic [1:0]  w_m_size, w_last, w_cnt_n;
    logic        w_m_sign, w_split;

    // Merge sees the live request while idle, the latched one afterwards.
    assign w_m_addr = (r_state == ST_IDLE) ? LSU_ADDR : r_addr;
    assign w_m_size = (r_state == ST_IDLE) ? LSU_SIZE : r_size;
    assign w_m_sign = (r_state == ST_IDLE) ? LSU_SIGN : r_sign;

    otter_lsu_merge #(.IO_BASE(IO_BASE)) u_merge (
        .i_addr  (w_m_addr),
        .i_size  (w_m_size),
        .i_sign  (w_m_sign),
        .i_asm   (w_asm_nxt),
        .o_split (w_split),
        .o_last  (w_last),
        .o_ext   (w_ext)
    );

    assign w_cnt_n    = r_cnt + 2'd1;
    assign w_nxt_addr = r_addr + {30'h0, w_cnt_n};

    // Assembly buffer with the byte currently returned by memory merged in.
    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_cnt, 3'b000} +: 8] = MEM_DOUT2[7:0];
    end

    // Request sequencer; all memory-side outputs are registered here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_asm      <= '0;
            r_rdata    <= '0;
            r_size     <= SZ_BYTE;
            r_cnt      <= '0;
            r_last     <= '0;
            r_sign     <= 1'b0;
            r_split    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_split_q  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_size <= SZ_BYTE;
            r_mem_sign <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_split_q <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (LSU_REQ) begin
                        r_addr  <= LSU_ADDR;
                        r_wdata <= LSU_WDATA;
                        r_size  <= LSU_SIZE;
                        r_sign  <= LSU_SIGN;
                        r_split <= w_split;
                        r_last  <= w_last;
                        r_cnt   <= '0;
                        r_asm   <= '0;
                        if (LSU_SIZE == SZ_ILL) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_mem_addr <= LSU_ADDR;
                            r_mem_size <= w_split ? SZ_BYTE : LSU_SIZE;
                            r_mem_sign <= w_split ? 1'b1 : LSU_SIGN;
                            r_mem_din  <= w_split ? piece_din(LSU_WDATA, 2'd0) : LSU_WDATA;
                            if (LSU_WE) begin
                                r_mem_wr <= 1'b1;
                                r_state  <= ST_WR;
                            end else begin
                                r_mem_rd <= 1'b1;
                                r_state  <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (r_cnt == r_last) begin
                        r_mem_wr  <= 1'b0;
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                        r_split_q <= r_split;
                    end else begin
                        r_cnt      <= w_cnt_n;
                        r_mem_addr <= w_nxt_addr;
                        r_mem_din  <= piece_din(r_wdata, w_cnt_n);
                    end
                end
                ST_RD: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= ST_CAP;
                end
                ST_CAP: begin
                    if (r_cnt == r_last) begin
                        r_rdata   <= r_split ? w_ext : MEM_DOUT2;
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                        r_split_q <= r_split;
                    end else begin
                        r_asm      <= w_asm_nxt;
                        r_cnt      <= w_cnt_n;
                        r_mem_addr <= w_nxt_addr;
                        r_mem_rd   <= 1'b1;
                        r_state    <= ST_RD;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign LSU_READY  = (r_state == ST_IDLE);
    assign LSU_DONE   = r_done;
    assign LSU_ERR    = r_err;
    assign LSU_SPLIT  = r_split_q;
    assign LSU_RDATA  = r_rdata;
    assign MEM_ADDR2  = r_mem_addr;
    assign MEM_DIN2   = r_mem_din;
    assign MEM_WRITE2 = r_mem_wr;
    assign MEM_READ2  = r_mem_rd;
    assign MEM_SIZE   = r_mem_size;
    assign MEM_SIGN   = r_mem_sign;

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a byte-addressed memory model.
module tb_otter_lsu;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LSU_REQ = 1'b0, LSU_WE = 1'b0, LSU_SIGN = 1'b0;
    logic [31:0] LSU_ADDR = '0, LSU_WDATA = '0;
    logic [1:0]  LSU_SIZE = '0;
    logic        LSU_READY, LSU_DONE, LSU_ERR, LSU_SPLIT;
    logic [31:0] LSU_RDATA, MEM_ADDR2, MEM_DIN2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_DOUT2 = '0;

    otter_lsu dut (
        .CLK(CLK), .RST(RST),
        .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE), .LSU_ADDR(LSU_ADDR),
        .LSU_WDATA(LSU_WDATA), .LSU_SIZE(LSU_SIZE), .LSU_SIGN(LSU_SIGN),
        .LSU_READY(LSU_READY), .LSU_DONE(LSU_DONE), .LSU_RDATA(LSU_RDATA),
        .LSU_ERR(LSU_ERR), .LSU_SPLIT(LSU_SPLIT),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    // Memory model: low 1 KiB of RAM, constant word above the MMIO base.
    logic [7:0] mem [0:1023];

    function automatic logic [31:0] mrd(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        if (a >= 32'h11000000) return 32'hCAFEF00D;
        if (a >= 32'd1021) return 32'h0;
        b = mem[a[9:0]];
        h = {mem[a[9:0] + 10'd1], mem[a[9:0]]};
        case (sz)
            2'd0:    return sg ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return sg ? {16'h0, h} : {{16{h[15]}}, h};
            default: return {mem[a[9:0] + 10'd3], mem[a[9:0] + 10'd2], h};
        endcase
    endfunction

    always @(posedge CLK) begin
        if (MEM_WRITE2 && MEM_ADDR2 < 32'd1021) begin
            mem[MEM_ADDR2[9:0]] = MEM_DIN2[7:0];
            if (MEM_SIZE != 2'd0) mem[MEM_ADDR2[9:0] + 10'd1] = MEM_DIN2[15:8];
            if (MEM_SIZE == 2'd2) begin
                mem[MEM_ADDR2[9:0] + 10'd2] = MEM_DIN2[23:16];
                mem[MEM_ADDR2[9:0] + 10'd3] = MEM_DIN2[31:24];
            end
        end
        if (MEM_READ2) MEM_DOUT2 <= mrd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
    end

    task automatic preset();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        {mem[259], mem[258], mem[257], mem[256]} = 32'h44332211;
        {mem[263], mem[262], mem[261], mem[260]} = 32'h88776685;
    endtask

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    int          cyc, done_cyc, nrd, nwr, both;
    logic        d_err, d_split;
    logic [1:0]  rd_sz;
    logic [31:0] rd_addr [0:3];

    // Issue one request and watch it to LSU_DONE; cyc counts from the accept edge.
    task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg);
        @(negedge CLK);
        LSU_REQ = 1'b1; LSU_WE = we; LSU_ADDR = a; LSU_WDATA = wd;
        LSU_SIZE = sz; LSU_SIGN = sg;
        @(posedge CLK);
        #1 LSU_REQ = 1'b0;
        cyc = 0; done_cyc = 0; nrd = 0; nwr = 0; both = 0;
        d_err = 1'b0; d_split = 1'b0; rd_sz = 2'd0;
        while (done_cyc == 0 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (MEM_READ2) begin
                if (nrd < 4) rd_addr[nrd] = MEM_ADDR2;
                if (nrd == 0) rd_sz = MEM_SIZE;
                nrd++;
            end
            if (MEM_WRITE2) nwr++;
            if (MEM_READ2 && MEM_WRITE2) both = 1;
            if (LSU_DONE) begin
                done_cyc = cyc; d_err = LSU_ERR; d_split = LSU_SPLIT;
            end
        end
        if (done_cyc == 0) chk("done_timeout", 32'd0, 32'd1);
        chk("rd_wr_overlap", both, 0);
    endtask

    initial begin
        preset();
        repeat (3) @(negedge CLK);
        // reset state
        chk("rst_ready", LSU_READY, 1);
        chk("rst_done",  LSU_DONE, 0);
        chk("rst_err",   LSU_ERR, 0);
        chk("rst_split", LSU_SPLIT, 0);
        chk("rst_strb",  {MEM_READ2, MEM_WRITE2}, 0);
        chk("rst_rdata", LSU_RDATA, 0);
        chk("rst_addr",  MEM_ADDR2, 0);
        chk("rst_din",   MEM_DIN2, 0);
        chk("rst_szsg",  {MEM_SIZE, MEM_SIGN}, 0);
        RST = 1'b0;

        // aligned word load
        run_req(1'b0, 32'h100, 0, 2'd2, 1'b0);
        chk("lw100_cyc", done_cyc, 3);
        chk("lw100_nrd", nrd, 1);
        chk("lw100_addr", rd_addr[0], 32'h100);
        chk("lw100_data", LSU_RDATA, 32'h44332211);
        chk("lw100_flags", {d_split, d_err}, 0);
        @(negedge CLK);
        chk("lw100_ready", LSU_READY, 1);

        // misaligned word load
        run_req(1'b0, 32'h102, 0, 2'd2, 1'b0);
        chk("lw102_cyc", done_cyc, 9);
        chk("lw102_nrd", nrd, 4);
        chk("lw102_a0", rd_addr[0], 32'h102);
        chk("lw102_a1", rd_addr[1], 32'h103);
        chk("lw102_a2", rd_addr[2], 32'h104);
        chk("lw102_a3", rd_addr[3], 32'h105);
        chk("lw102_data", LSU_RDATA, 32'h66854433);
        chk("lw102_split", d_split, 1);

        // byte load, signed, memory extends
        run_req(1'b0, 32'h104, 0, 2'd0, 1'b0);
        chk("lb104_data", LSU_RDATA, 32'hFFFFFF85);
        chk("lb104_split", d_split, 0);

        // split half loads, signed then unsigned
        run_req(1'b0, 32'h103, 0, 2'd1, 1'b0);
        chk("lh103_cyc", done_cyc, 5);
        chk("lh103_data", LSU_RDATA, 32'hFFFF8544);
        chk("lh103_split", d_split, 1);
        run_req(1'b0, 32'h103, 0, 2'd1, 1'b1);
        chk("lhu103_cyc", done_cyc, 5);
        chk("lhu103_data", LSU_RDATA, 32'h00008544);

        // split word store and read-back
        run_req(1'b1, 32'h101, 32'hAABBCCDD, 2'd2, 1'b0);
        chk("sw101_cyc", done_cyc, 5);
        chk("sw101_nwr", nwr, 4);
        chk("sw101_split", d_split, 1);
        run_req(1'b0, 32'h100, 0, 2'd2, 1'b0);
        chk("rb100_data", LSU_RDATA, 32'hBBCCDD11);
        run_req(1'b0, 32'h104, 0, 2'd2, 1'b0);
        chk("rb104_data", LSU_RDATA, 32'h887766AA);

        // aligned store, then split half store overlapping it
        run_req(1'b1, 32'h200, 32'h12345678, 2'd2, 1'b0);
        chk("sw200_cyc", done_cyc, 2);
        chk("sw200_nwr", nwr, 1);
        run_req(1'b1, 32'h1FF, 32'h0000BEEF, 2'd1, 1'b0);
        chk("sh1ff_cyc", done_cyc, 3);
        chk("sh1ff_nwr", nwr, 2);
        run_req(1'b0, 32'h200, 0, 2'd2, 1'b0);
        chk("rb200_data", LSU_RDATA, 32'h123456BE);

        // MMIO misaligned word is not split
        run_req(1'b0, 32'h11000002, 0, 2'd2, 1'b0);
        chk("mmio_nrd", nrd, 1);
        chk("mmio_size", rd_sz, 2);
        chk("mmio_split", d_split, 0);
        chk("mmio_data", LSU_RDATA, 32'hCAFEF00D);

        // illegal size
        run_req(1'b0, 32'h100, 0, 2'd3, 1'b0);
        chk("ill_cyc", done_cyc, 1);
        chk("ill_err", d_err, 1);
        chk("ill_strb", nrd + nwr, 0);
        chk("ill_rdata", LSU_RDATA, 32'hCAFEF00D);

        // reset in the middle of a split store
        @(negedge CLK);
        preset();
        LSU_REQ = 1'b1; LSU_WE = 1'b1; LSU_ADDR = 32'h101;
        LSU_WDATA = 32'hAABBCCDD; LSU_SIZE = 2'd2; LSU_SIGN = 1'b0;
        @(posedge CLK);
        #1 LSU_REQ = 1'b0;
        @(negedge CLK);
        chk("rmid_wr1", {MEM_WRITE2, MEM_ADDR2}, {1'b1, 32'h101});
        @(negedge CLK);
        chk("rmid_wr2", {MEM_WRITE2, MEM_ADDR2}, {1'b1, 32'h102});
        RST = 1'b1;
        #1;
        chk("rmid_strb", {MEM_READ2, MEM_WRITE2}, 0);
        chk("rmid_ready", LSU_READY, 1);
        @(negedge CLK);
        RST = 1'b0;
        done_cyc = 0;
        repeat (6) begin
            @(negedge CLK);
            if (LSU_DONE) done_cyc = 1;
        end
        chk("rmid_nodone", done_cyc, 0);
        chk("rmid_ready2", LSU_READY, 1);
        chk("rmid_b101", mem[257], 8'hDD);
        chk("rmid_b102", mem[258], 8'h33);
        chk("rmid_b104", mem[260], 8'h85);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
